// File: rtl/serdes_pkg.sv
// Shared constants and types for the serializer symbol scheduler.
package serdes_pkg;

    localparam logic [7:0] K28_5            = 8'hBC;
    localparam int         SYM_BITS_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        RUN
    } tx_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner search over NUM_REQ requests, starting at a registered
// pointer that advances past the granted index when told to.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       ptr_update,
    input  logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       valid
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      ptr_d;
    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] masked_req;
    logic [NUM_REQ-1:0] pick_src;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign upper_mask[gi] = (PW'(gi) >= ptr_q);
        end
    endgenerate

    // Prefer requests at or above the pointer; fall back to the wrapped range.
    assign masked_req = req & upper_mask;
    assign pick_src   = (|masked_req) ? masked_req : req;
    assign grant      = pick_src & (~pick_src + NUM_REQ'(1));
    assign valid      = |req;

    always_comb begin
        ptr_d = ptr_q;
        if (ptr_update) begin
            ptr_d = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/serdes_tx_sched.sv
// Shares one serial lane among NUM_REQ byte sources, pacing loads to the PISO
// symbol period and inserting K28.5 commas for alignment and resync.
module serdes_tx_sched
    import serdes_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int SYM_BITS    = SYM_BITS_DEFAULT,
    parameter int SYNC_PERIOD = 16,
    parameter int ALIGN_SYMS  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ser_en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_k,
    output logic                       tx_load,
    output logic [$clog2(NUM_REQ)-1:0] tx_src,
    output logic                       link_up
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int SW = $clog2(SYM_BITS);
    localparam int YW = $clog2(SYNC_PERIOD);
    localparam int AW = $clog2(ALIGN_SYMS + 1);

    localparam logic [SW-1:0] SLOT_LAST  = SW'(SYM_BITS - 1);
    localparam logic [YW-1:0] SYNC_LAST  = YW'(SYNC_PERIOD - 1);
    localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_SYMS - 1);

    tx_state_t     state_q, state_d;
    logic [SW-1:0] slot_cnt_q, slot_cnt_d;
    logic [YW-1:0] sync_cnt_q, sync_cnt_d;
    logic [AW-1:0] align_cnt_q, align_cnt_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_k_q, tx_k_d;
    logic          tx_load_q, tx_load_d;
    logic [PW-1:0] tx_src_q, tx_src_d;
    logic          link_up_q, link_up_d;

    logic               decision;
    logic               data_sel;
    logic [NUM_REQ-1:0] arb_grant;
    logic               arb_valid;
    logic [PW-1:0]      grant_idx;
    logic [7:0]         win_byte;
    logic [PW-1:0]      enc_chain [NUM_REQ+1];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (req_valid),
        .ptr_update (data_sel),
        .grant_idx  (grant_idx),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    assign enc_chain[0] = '0;
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_enc
            assign enc_chain[gi+1] = enc_chain[gi] | (arb_grant[gi] ? PW'(gi) : '0);
        end
    endgenerate
    assign grant_idx = enc_chain[NUM_REQ];
    assign win_byte  = req_data[{grant_idx, 3'b000} +: 8];

    // A dropped enable cancels the slot, so it also suppresses the decision.
    assign decision  = (state_q != IDLE) && ser_en && (slot_cnt_q == SLOT_LAST);
    assign data_sel  = decision && (state_q == RUN) && (sync_cnt_q != SYNC_LAST) && arb_valid;
    assign req_ready = data_sel ? arb_grant : '0;

    always_comb begin
        state_d     = state_q;
        slot_cnt_d  = slot_cnt_q;
        sync_cnt_d  = sync_cnt_q;
        align_cnt_d = align_cnt_q;
        tx_data_d   = tx_data_q;
        tx_k_d      = tx_k_q;
        tx_src_d    = tx_src_q;
        tx_load_d   = 1'b0;

        if (state_q == IDLE) begin
            if (ser_en) begin
                state_d = ALIGN;
            end
        end else if (!ser_en) begin
            state_d     = IDLE;
            slot_cnt_d  = '0;
            sync_cnt_d  = '0;
            align_cnt_d = '0;
        end else begin
            slot_cnt_d = (slot_cnt_q == SLOT_LAST) ? '0 : slot_cnt_q + SW'(1);
            if (decision) begin
                tx_load_d = 1'b1;
                if (data_sel) begin
                    tx_data_d  = win_byte;
                    tx_k_d     = 1'b0;
                    tx_src_d   = grant_idx;
                    sync_cnt_d = sync_cnt_q + YW'(1);
                end else begin
                    tx_data_d  = K28_5;
                    tx_k_d     = 1'b1;
                    sync_cnt_d = '0;
                    if (state_q == ALIGN) begin
                        align_cnt_d = align_cnt_q + AW'(1);
                        if (align_cnt_q == ALIGN_LAST) begin
                            state_d = RUN;
                        end
                    end
                end
            end
        end

        link_up_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            slot_cnt_q  <= '0;
            sync_cnt_q  <= '0;
            align_cnt_q <= '0;
            tx_data_q   <= '0;
            tx_k_q      <= 1'b0;
            tx_load_q   <= 1'b0;
            tx_src_q    <= '0;
            link_up_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_cnt_q  <= slot_cnt_d;
            sync_cnt_q  <= sync_cnt_d;
            align_cnt_q <= align_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_k_q      <= tx_k_d;
            tx_load_q   <= tx_load_d;
            tx_src_q    <= tx_src_d;
            link_up_q   <= link_up_d;
        end
    end

    assign tx_data = tx_data_q;
    assign tx_k    = tx_k_q;
    assign tx_load = tx_load_q;
    assign tx_src  = tx_src_q;
    assign link_up = link_up_q;

endmodule

// File: tb/tb_serdes_tx_sched.sv
// Self-checking bench for serdes_tx_sched: directed symbol sequences, a vector
// table and a randomized run against a symbol-level reference model.
module tb_serdes_tx_sched;

    localparam int NR  = 4;
    localparam int SYM = 10;
    localparam int SP  = 16;
    localparam int AS  = 4;
    localparam logic [7:0] COMMA = 8'hBC;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            ser_en = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_ready;
    logic [7:0]      tx_data;
    logic            tx_k;
    logic            tx_load;
    logic [1:0]      tx_src;
    logic            link_up;

    int checks = 0;
    int errors = 0;
    int since_en = 0;
    logic [1:0] cur_src = 2'd0;

    typedef struct {
        logic [NR-1:0] valid;
        logic [NR-1:0] ready;
        logic          k;
        logic [7:0]    data;
        logic [1:0]    src;
    } vec_t;

    vec_t tbl [14];

    always #5 clk = ~clk;

    serdes_tx_sched #(
        .NUM_REQ     (NR),
        .SYM_BITS    (SYM),
        .SYNC_PERIOD (SP),
        .ALIGN_SYMS  (AS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ser_en    (ser_en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_k      (tx_k),
        .tx_load   (tx_load),
        .tx_src    (tx_src),
        .link_up   (link_up)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        since_en++;
    endtask

    // Runs up to and through the next decision cycle; counts stray strobes.
    task automatic do_symbol(input logic [NR-1:0] v, output logic [NR-1:0] rdy, output int stray);
        req_valid = v;
        stray = 0;
        for (int i = 0; i < SYM && (since_en % SYM) != 0; i++) begin
            #1;
            if (req_ready != '0) stray++;
            tick();
            if (tx_load !== 1'b0) stray++;
        end
        #1;
        rdy = req_ready;
        tick();
    endtask

    task automatic expect_sym(input string name, input logic [NR-1:0] v, input logic [NR-1:0] exp_rdy,
                              input logic exp_k, input logic [7:0] exp_data, input logic [1:0] exp_src,
                              input logic exp_link);
        logic [NR-1:0] rdy;
        int stray;
        do_symbol(v, rdy, stray);
        chk({name, " ready"}, 32'(rdy), 32'(exp_rdy));
        chk({name, " load"}, 32'(tx_load), 32'd1);
        chk({name, " k"}, 32'(tx_k), 32'(exp_k));
        chk({name, " data"}, 32'(tx_data), 32'(exp_data));
        chk({name, " src"}, 32'(tx_src), 32'(exp_src));
        chk({name, " link_up"}, 32'(link_up), 32'(exp_link));
        chk({name, " stray strobes"}, 32'(stray), 32'd0);
        $display("sym %-8s valid=%b ready=%b load=%0d k=%0d data=%02h src=%0d link=%0d",
                 name, v, rdy, tx_load, tx_k, tx_data, tx_src, link_up);
    endtask

    task automatic start_link();
        ser_en = 1'b1;
        tick();
        since_en = 1;
        for (int s = 1; s <= AS; s++) begin
            expect_sym("align", '0, '0, 1'b1, COMMA, cur_src, s == AS);
        end
    endtask

    task automatic random_phase();
        int m_mode, m_since, m_commas, m_run, m_ptr, w, idx;
        logic [7:0]    e_data;
        logic          e_k, e_load, e_link;
        logic [1:0]    e_src;
        logic [NR-1:0] e_rdy;
        reset = 1'b1;
        ser_en = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_mode = 0; m_since = 0; m_commas = 0; m_run = 0; m_ptr = 0;
        e_data = 8'h00; e_k = 1'b0; e_src = 2'd0; e_link = 1'b0;
        ser_en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (c > 0) begin
                if (ser_en && $urandom_range(0, 399) == 0) ser_en = 1'b0;
                else if (!ser_en && $urandom_range(0, 7) == 0) ser_en = 1'b1;
            end
            req_valid = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom);
            req_data  = 32'($urandom);
            #1;
            e_rdy = '0;
            e_load = 1'b0;
            if (m_mode == 0) begin
                if (ser_en) begin
                    m_mode = 1;
                    m_since = 1;
                end
            end else if (!ser_en) begin
                m_mode = 0; m_since = 0; m_commas = 0; m_run = 0;
            end else begin
                if (m_since % SYM == 0) begin
                    e_load = 1'b1;
                    w = -1;
                    if (m_mode == 2 && m_run < SP - 1) begin
                        for (int k = 0; k < NR; k++) begin
                            idx = (m_ptr + k) % NR;
                            if (w < 0 && req_valid[idx[1:0]]) w = idx;
                        end
                    end
                    if (w >= 0) begin
                        e_rdy  = NR'(1) << w;
                        e_data = req_data[8*w +: 8];
                        e_k    = 1'b0;
                        e_src  = 2'(w);
                        m_run++;
                        m_ptr  = (w + 1) % NR;
                    end else begin
                        e_data = COMMA;
                        e_k    = 1'b1;
                        m_run  = 0;
                        if (m_mode == 1) begin
                            m_commas++;
                            if (m_commas == AS) m_mode = 2;
                        end
                    end
                end
                m_since++;
            end
            e_link = (m_mode == 2);
            chk("rand ready", 32'(req_ready), 32'(e_rdy));
            @(posedge clk);
            #1;
            chk("rand load", 32'(tx_load), 32'(e_load));
            chk("rand data", 32'(tx_data), 32'(e_data));
            chk("rand k", 32'(tx_k), 32'(e_k));
            chk("rand src", 32'(tx_src), 32'(e_src));
            chk("rand link_up", 32'(link_up), 32'(e_link));
            if (e_load) begin
                $display("rand cyc=%0d en=%0d k=%0d data=%02h src=%0d link=%0d",
                         c, ser_en, tx_k, tx_data, tx_src, link_up);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int loads;

        tbl[0]  = '{4'b1111, 4'b0001, 1'b0, 8'h10, 2'd0};
        tbl[1]  = '{4'b1111, 4'b0010, 1'b0, 8'h11, 2'd1};
        tbl[2]  = '{4'b1111, 4'b0100, 1'b0, 8'h12, 2'd2};
        tbl[3]  = '{4'b1111, 4'b1000, 1'b0, 8'h13, 2'd3};
        tbl[4]  = '{4'b1111, 4'b0001, 1'b0, 8'h10, 2'd0};
        tbl[5]  = '{4'b1111, 4'b0010, 1'b0, 8'h11, 2'd1};
        tbl[6]  = '{4'b0000, 4'b0000, 1'b1, 8'hBC, 2'd1};
        tbl[7]  = '{4'b0001, 4'b0001, 1'b0, 8'h10, 2'd0};
        tbl[8]  = '{4'b0001, 4'b0001, 1'b0, 8'h10, 2'd0};
        tbl[9]  = '{4'b1001, 4'b1000, 1'b0, 8'h13, 2'd3};
        tbl[10] = '{4'b0110, 4'b0010, 1'b0, 8'h11, 2'd1};
        tbl[11] = '{4'b0110, 4'b0100, 1'b0, 8'h12, 2'd2};
        tbl[12] = '{4'b0011, 4'b0001, 1'b0, 8'h10, 2'd0};
        tbl[13] = '{4'b1000, 4'b1000, 1'b0, 8'h13, 2'd3};

        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = '1;
        reset     = 1'b1;
        ser_en    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset tx_data", 32'(tx_data), 32'd0);
        chk("reset tx_k", 32'(tx_k), 32'd0);
        chk("reset tx_load", 32'(tx_load), 32'd0);
        chk("reset tx_src", 32'(tx_src), 32'd0);
        chk("reset link_up", 32'(link_up), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        $display("reset state checked");
        reset = 1'b0;
        req_valid = '0;
        cur_src = 2'd0;
        tick();

        // Link bring-up, then idle commas with no requests.
        start_link();
        repeat (2) expect_sym("idle", '0, '0, 1'b1, COMMA, cur_src, 1'b1);

        req_data[7:0] = 8'h55;
        expect_sym("single", 4'b0001, 4'b0001, 1'b0, 8'h55, 2'd0, 1'b1);
        cur_src = 2'd0;
        req_data[7:0] = 8'h10;
        expect_sym("clr", '0, '0, 1'b1, COMMA, cur_src, 1'b1);

        // One requester streaming: 15 data then a forced comma.
        for (int s = 1; s <= 40; s++) begin
            if (s % SP == 0) begin
                expect_sym("forced", 4'b0010, '0, 1'b1, COMMA, cur_src, 1'b1);
            end else begin
                expect_sym("stream", 4'b0010, 4'b0010, 1'b0, 8'h11, 2'd1, 1'b1);
                cur_src = 2'd1;
            end
        end

        // Reset lands in a decision cycle that would grant requester 2.
        req_valid = 4'b0100;
        for (int i = 0; i < SYM && (since_en % SYM) != 0; i++) tick();
        #1;
        chk("pre-reset ready", 32'(req_ready), 32'b0100);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset tx_load", 32'(tx_load), 32'd0);
        chk("async reset tx_data", 32'(tx_data), 32'd0);
        chk("async reset tx_k", 32'(tx_k), 32'd0);
        chk("async reset tx_src", 32'(tx_src), 32'd0);
        chk("async reset link_up", 32'(link_up), 32'd0);
        chk("async reset req_ready", 32'(req_ready), 32'd0);
        $display("mid-slot reset checked");
        @(posedge clk);
        #1;
        reset = 1'b0;
        cur_src = 2'd0;
        start_link();

        for (int t = 0; t < 14; t++) begin
            expect_sym("table", tbl[t].valid, tbl[t].ready, tbl[t].k, tbl[t].data, tbl[t].src, 1'b1);
            cur_src = tbl[t].src;
        end

        // Enable dropped mid-slot with all requesters valid.
        req_valid = '1;
        repeat (5) tick();
        ser_en = 1'b0;
        tick();
        chk("drop link_up", 32'(link_up), 32'd0);
        loads = 0;
        repeat (25) begin
            #1;
            if (req_ready != '0) loads++;
            tick();
            if (tx_load !== 1'b0) loads++;
        end
        chk("disabled activity", 32'(loads), 32'd0);
        $display("ser_en drop checked, activity=%0d", loads);
        start_link();
        expect_sym("relink", 4'b1111, 4'b0001, 1'b0, 8'h10, 2'd0, 1'b1);

        random_phase();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
